// File: rtl/opl3_timers.sv
// opl3_timers: the two OPL3 interval timers (80 us and 320 us resolution).
//
// Ports
//   clk          single clock
//   reset_n      synchronous active-low reset
//   opl3_reg_wr  register write stream {valid, bank_num, address, data}
//   status       registered status byte {irq, ft1, ft2, 5'b0}
//   irq_n        registered active-low interrupt (~(ft1 | ft2))
//
// Bank-0 registers 0x02 (treg1), 0x03 (treg2) and 0x04 (control) are decoded.
// A free-running prescaler produces tick1; a divider on tick1 produces tick2.
// Each running timer increments its counter per tick and, on overflow from
// 0xFF, reloads from its treg and raises its flag unless masked.

package opl3_timers_pkg;
    typedef struct packed {
        logic       valid;
        logic       bank_num;
        logic [7:0] address;
        logic [7:0] data;
    } opl3_reg_wr_t;
endpackage

module opl3_timers
    import opl3_timers_pkg::*;
#(
    parameter int unsigned TICK1_CYCLES = 1018,
    parameter int unsigned TICK2_DIV    = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  opl3_reg_wr_t opl3_reg_wr,
    output logic [7:0]   status,
    output logic         irq_n
);

    localparam int unsigned PreW = (TICK1_CYCLES > 2) ? $clog2(TICK1_CYCLES) : 1;
    localparam int unsigned DivW = (TICK2_DIV > 4) ? $clog2(TICK2_DIV) : 2;

    logic [PreW-1:0] presc_q, presc_d;
    logic [DivW-1:0] div_q, div_d;
    logic            tick1, tick2;
    logic [1:0]      tick;

    logic [7:0] treg_q [2];
    logic [7:0] treg_d [2];
    logic [7:0] cnt_q  [2];
    logic [7:0] cnt_d  [2];
    logic [1:0] st_q, st_d, st_prev_q, mask_q, mask_d, ft_q, ft_d;
    logic [7:0] status_q, status_d;
    logic       irq_n_q, irq_n_d;

    logic wr_hit, wr_t1, wr_t2, wr_ctl;
    logic unused_data;

    assign wr_hit = opl3_reg_wr.valid && !opl3_reg_wr.bank_num;
    assign wr_t1  = wr_hit && (opl3_reg_wr.address == 8'h02);
    assign wr_t2  = wr_hit && (opl3_reg_wr.address == 8'h03);
    assign wr_ctl = wr_hit && (opl3_reg_wr.address == 8'h04);
    assign unused_data = ^opl3_reg_wr.data[4:2];

    // Prescaler wrap marks tick1; every TICK2_DIV-th tick1 is also tick2.
    assign tick1 = (presc_q == PreW'(TICK1_CYCLES - 1));
    assign tick2 = tick1 && (div_q == DivW'(TICK2_DIV - 1));
    assign tick  = {tick2, tick1};

    always_comb begin
        presc_d = tick1 ? '0 : presc_q + 1'b1;
        div_d   = div_q;
        if (tick1) begin
            div_d = tick2 ? '0 : div_q + 1'b1;
        end
    end

    always_comb begin
        treg_d = treg_q;
        cnt_d  = cnt_q;
        st_d   = st_q;
        mask_d = mask_q;
        ft_d   = ft_q;

        if (wr_t1) treg_d[0] = opl3_reg_wr.data;
        if (wr_t2) treg_d[1] = opl3_reg_wr.data;

        if (wr_ctl) begin
            if (opl3_reg_wr.data[7]) begin
                ft_d = '0;
            end else begin
                mask_d = {opl3_reg_wr.data[5], opl3_reg_wr.data[6]};
                st_d   = {opl3_reg_wr.data[1], opl3_reg_wr.data[0]};
            end
        end

        // Overflow is applied after the RST clear so a coincident overflow wins.
        for (int i = 0; i < 2; i++) begin
            if (st_q[i] && !st_prev_q[i]) begin
                // First cycle after start: load, swallowing any tick.
                cnt_d[i] = treg_q[i];
            end else if (st_q[i] && tick[i]) begin
                if (cnt_q[i] == 8'hFF) begin
                    cnt_d[i] = treg_q[i];
                    if (!mask_q[i]) ft_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
        end

        status_d = {ft_d[0] | ft_d[1], ft_d[0], ft_d[1], 5'b0};
        irq_n_d  = ~(ft_d[0] | ft_d[1]);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_q   <= '0;
            div_q     <= '0;
            treg_q    <= '{default: '0};
            cnt_q     <= '{default: '0};
            st_q      <= '0;
            st_prev_q <= '0;
            mask_q    <= '0;
            ft_q      <= '0;
            status_q  <= '0;
            irq_n_q   <= 1'b1;
        end else begin
            presc_q   <= presc_d;
            div_q     <= div_d;
            treg_q    <= treg_d;
            cnt_q     <= cnt_d;
            st_q      <= st_d;
            st_prev_q <= st_q;
            mask_q    <= mask_d;
            ft_q      <= ft_d;
            status_q  <= status_d;
            irq_n_q   <= irq_n_d;
        end
    end

    assign status = status_q;
    assign irq_n  = irq_n_q;

endmodule

// File: tb/tb_opl3_timers.sv
// Directed bench for opl3_timers with TICK1_CYCLES=4, TICK2_DIV=4.
// n counts clock edges since the last reset release; tick1 lands on edges
// where n%4==0 and tick2 on edges where n%16==0.
module tb_opl3_timers;
    import opl3_timers_pkg::*;

    logic         clk;
    logic         reset_n;
    opl3_reg_wr_t opl3_reg_wr;
    logic [7:0]   status;
    logic         irq_n;

    int checks = 0;
    int errors = 0;
    int n = 0;
    logic [7:0] bad;

    opl3_timers #(
        .TICK1_CYCLES(4),
        .TICK2_DIV   (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opl3_reg_wr(opl3_reg_wr),
        .status     (status),
        .irq_n      (irq_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic goto(input int t);
        while (n < t) step(1);
    endtask

    task automatic wr(input logic v, input logic bank, input logic [7:0] addr,
                      input logic [7:0] data);
        opl3_reg_wr = '{valid: v, bank_num: bank, address: addr, data: data};
        step(1);
        opl3_reg_wr = '0;
    endtask

    task automatic do_reset(input int k);
        reset_n = 1'b0;
        step(k);
        reset_n = 1'b1;
        n = 0;
    endtask

    initial begin
        opl3_reg_wr = '0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);
        check("reset_status", status, 8'h00);
        check("reset_irq_n", {7'b0, irq_n}, 8'h01);

        // Timer 1 with treg=0xFE: load at 3, 0xFF at 4, overflow at 8.
        wr(1'b1, 1'b0, 8'h02, 8'hFE);
        wr(1'b1, 1'b0, 8'h04, 8'h01);
        goto(7);
        check("t1_before_ovf", status, 8'h00);
        goto(8);
        check("t1_ovf_status", status, 8'hC0);
        check("t1_ovf_irq_n", {7'b0, irq_n}, 8'h00);
        check("t1_reload", dut.cnt_q[0], 8'hFE);
        goto(12);
        check("t1_cnt_ff", dut.cnt_q[0], 8'hFF);
        goto(16);
        check("t1_reload2", dut.cnt_q[0], 8'hFE);
        check("t1_flag_held", status, 8'hC0);

        // RST clears the flag but leaves timer 1 running.
        wr(1'b1, 1'b0, 8'h04, 8'h80);
        check("rst_clear", status, 8'h00);
        goto(20);
        check("rst_still_running", dut.cnt_q[0], 8'hFF);
        goto(24);
        check("rst_ovf_again", status, 8'hC0);
        wr(1'b1, 1'b0, 8'h04, 8'h80);
        check("rst_clear2", status, 8'h00);

        // RST written on the overflow edge (32): set wins.
        goto(31);
        check("coll_before", status, 8'h00);
        wr(1'b1, 1'b0, 8'h04, 8'h80);
        check("collision_set_wins", status, 8'hC0);

        // Both timers overflowing on edge 48.
        wr(1'b1, 1'b0, 8'h04, 8'h80);
        wr(1'b1, 1'b0, 8'h02, 8'hFF);
        wr(1'b1, 1'b0, 8'h03, 8'hFF);
        wr(1'b1, 1'b0, 8'h04, 8'h03);
        goto(39);
        check("both_pre40", status, 8'h00);
        goto(40);
        check("t1_only_40", status, 8'hC0);
        goto(44);
        wr(1'b1, 1'b0, 8'h04, 8'h80);
        goto(47);
        check("both_pre48", status, 8'h00);
        goto(48);
        check("both_ovf", status, 8'hE0);

        // Masked timer 1 (treg=0xFF) for 300 ticks.
        wr(1'b1, 1'b0, 8'h04, 8'h80);
        wr(1'b1, 1'b0, 8'h04, 8'h41);
        bad = 8'h00;
        repeat (1200) begin
            step(1);
            if (status !== 8'h00) bad = status;
        end
        check("mask_quiet", bad, 8'h00);

        // Unmask, then a one-cycle reset mid-count.
        wr(1'b1, 1'b0, 8'h04, 8'h01);
        do_reset(1);
        check("midreset_status", status, 8'h00);
        check("midreset_irq_n", {7'b0, irq_n}, 8'h01);
        check("midreset_cnt1", dut.cnt_q[0], 8'h00);

        // Ignored writes: bank 1, invalid, wrong address.
        wr(1'b1, 1'b1, 8'h04, 8'h01);
        wr(1'b0, 1'b0, 8'h04, 8'h01);
        wr(1'b1, 1'b0, 8'h05, 8'h01);
        bad = 8'h00;
        repeat (2000) begin
            step(1);
            if (status !== 8'h00 || irq_n !== 1'b1) bad = 8'hFF;
        end
        check("ignored_quiet", bad, 8'h00);
        check("ignored_st", {6'b0, dut.st_q}, 8'h00);

        // Timer 2 with treg=0xFF: overflow at every tick2 (edges 16, 32).
        do_reset(1);
        wr(1'b1, 1'b0, 8'h03, 8'hFF);
        wr(1'b1, 1'b0, 8'h04, 8'h02);
        goto(15);
        check("t2_before", status, 8'h00);
        goto(16);
        check("t2_ovf", status, 8'hA0);
        check("t2_irq_n", {7'b0, irq_n}, 8'h00);
        wr(1'b1, 1'b0, 8'h04, 8'h80);
        check("t2_clear", status, 8'h00);
        goto(31);
        check("t2_before2", status, 8'h00);
        goto(32);
        check("t2_ovf2", status, 8'hA0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
